rr_decoder_arbiter: RTL

//   Round-robin arbiter that shares one downstream resource among 2**N requesters.

---
 rtl/rr_decoder_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 2**N requesters with a registered one-hot grant.
// Ports: clk, rst_n, req[NREQ] -> gnt[NREQ], gnt_idx[N], gnt_valid, timeout.
module rr_decoder_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2**N-1:0]     req,
    output logic [2**N-1:0]     gnt,
    output logic [N-1:0]        gnt_idx,
    output logic                gnt_valid,
    output logic                timeout
);

    localparam int NREQ = 2**N;
    localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     hold_q, hold_d;
    logic [N-1:0]    last_q, last_d;

    logic            win_found;
    logic [N-1:0]    win_idx;
    logic [N-1:0]    cand;
    logic            hold_at_lim;

    // Scan upward from last_q+1; the N-bit add wraps, so the last owner
    // comes up last (offset NREQ truncates to 0).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_q + N'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign hold_at_lim = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    gnt_d   = ONE << win_idx;
                    hold_d  = 16'd1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    gnt_d   = '0;
                end
            end
            BUSY: begin
                if (!req[idx_q] || hold_at_lim) begin
                    state_d   = GAP;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    gnt_d     = '0;
                    hold_d    = '0;
                    last_d    = idx_q;
                    // Only a forced release of a still-requesting owner
                    timeout_d = req[idx_q];
                end else if (hold_q != 16'hFFFF) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= N'(NREQ - 1);
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule
